// File: rtl/vip_video_packet_framer.sv
// Builds Avalon-ST Video packets from a raw pixel stream: a control packet per frame,
// then an image packet. The output is a single register stage with zero-latency ready.
module vip_video_packet_framer #(
  parameter int unsigned DATA_WIDTH       = 10,
  parameter int unsigned DIM_BITS         = 16,
  parameter logic [3:0]  INTERLACE_NIBBLE = 4'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [DIM_BITS-1:0]   frame_width,
  input  logic [DIM_BITS-1:0]   frame_height,
  output logic                  busy,
  output logic                  frame_done,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  input  logic                  int_ready,
  output logic                  int_valid,
  output logic [DATA_WIDTH-1:0] int_data,
  output logic                  int_sop,
  output logic                  int_eop
);

  typedef enum logic [1:0] {StIdle, StCtrl, StImgHdr, StImgData} state_e;

  state_e                state_q, state_d;
  logic [3:0]            beat_q, beat_d;
  logic [DIM_BITS-1:0]   x_q, x_d, y_q, y_d;
  logic [DIM_BITS-1:0]   width_q, width_d, height_q, height_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic       load_en;
  logic       x_last, y_last;
  logic [3:0] nib;

  assign load_en = ~valid_q | int_ready;
  assign x_last  = (x_q == width_q - DIM_BITS'(1));
  assign y_last  = (y_q == height_q - DIM_BITS'(1));

  // Control packet payload: width nibbles MSB first, then height, then interlace.
  always_comb begin
    nib = INTERLACE_NIBBLE;
    case (beat_q)
      4'd1:    nib = width_q[15:12];
      4'd2:    nib = width_q[11:8];
      4'd3:    nib = width_q[7:4];
      4'd4:    nib = width_q[3:0];
      4'd5:    nib = height_q[15:12];
      4'd6:    nib = height_q[11:8];
      4'd7:    nib = height_q[7:4];
      4'd8:    nib = height_q[3:0];
      default: nib = INTERLACE_NIBBLE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    x_d       = x_q;
    y_d       = y_q;
    width_d   = width_q;
    height_d  = height_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    data_d    = data_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    pix_ready = 1'b0;

    if (load_en) valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        // Busy stays up until the final image beat actually leaves the output register.
        if (busy_q && valid_q && int_ready && eop_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (!busy_q && go && (frame_width != '0) && (frame_height != '0)) begin
          width_d      = frame_width;
          height_d     = frame_height;
          busy_d       = 1'b1;
          valid_d      = 1'b1;
          data_d       = '0;
          data_d[3:0]  = 4'hF;
          sop_d        = 1'b1;
          eop_d        = 1'b0;
          beat_d       = 4'd1;
          state_d      = StCtrl;
        end
      end
      StCtrl: begin
        if (load_en) begin
          valid_d     = 1'b1;
          data_d      = '0;
          data_d[3:0] = nib;
          sop_d       = 1'b0;
          eop_d       = (beat_q == 4'd9);
          if (beat_q == 4'd9) begin
            beat_d  = 4'd0;
            state_d = StImgHdr;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      StImgHdr: begin
        if (load_en) begin
          valid_d = 1'b1;
          data_d  = '0;
          sop_d   = 1'b1;
          eop_d   = 1'b0;
          x_d     = '0;
          y_d     = '0;
          state_d = StImgData;
        end
      end
      StImgData: begin
        pix_ready = load_en;
        if (load_en && pix_valid) begin
          valid_d = 1'b1;
          data_d  = pix_data;
          sop_d   = 1'b0;
          eop_d   = x_last && y_last;
          if (x_last) begin
            x_d = '0;
            y_d = y_q + DIM_BITS'(1);
          end else begin
            x_d = x_q + DIM_BITS'(1);
          end
          if (x_last && y_last) begin
            x_d     = '0;
            y_d     = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      width_q  <= '0;
      height_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      x_q      <= x_d;
      y_q      <= y_d;
      width_q  <= width_d;
      height_q <= height_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign int_valid  = valid_q;
  assign int_data   = data_q;
  assign int_sop    = sop_q;
  assign int_eop    = eop_q;

endmodule
